uart_rx_fifo: RTL

- Receive-side byte buffer between the uart_rx receiver and the memory controller's UART RX register path.
- Captures every uart_rx_valid byte into a circular FIFO so firmware polling at low rate over SPI-fetched code loses no characters.
- Presents a first-word-fall-through pop interface plus status flags: empty, full, level, overrun and break.

---
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte/status bundle between uart_rx, the RX FIFO and the mem_ctl register path.
// slave = FIFO side, master = the uart_rx/register-path side driving it.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
);
    logic                       rx_valid;
    logic [DATA_W-1:0]          rx_data;
    logic                       rx_break;
    logic                       rx_en;
    logic                       rd_en;
    logic [DATA_W-1:0]          rd_data;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH):0]     level;
    logic                       overrun;
    logic                       break_seen;
    logic                       clr_status;
    logic                       irq_thresh;

    modport slave (
        input  rx_valid, rx_data, rx_break, rd_en, clr_status,
        output rx_en, rd_data, empty, full, level, overrun, break_seen, irq_thresh
    );

    modport master (
        output rx_valid, rx_data, rx_break, rd_en, clr_status,
        input  rx_en, rd_data, empty, full, level, overrun, break_seen, irq_thresh
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overrun/break status.
// Define UART_RX_FIFO_THRESH_IRQ_EN to build the registered irq_thresh comparator.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned THRESH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
        $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              overrun_q, overrun_d;
    logic              break_seen_q, break_seen_d;
    logic              brk_q;
    logic              empty, full, pop, wr, drop, brk_rise;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LvlW'(DEPTH));
    assign pop      = bus.rd_en && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr       = bus.rx_valid && (!full || pop);
    assign drop     = bus.rx_valid && full && !pop;
    assign brk_rise = bus.rx_break && !brk_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overrun_d    = overrun_q;
        break_seen_d = break_seen_q;

        if (wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);

        case ({wr, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        // Set has priority over a coincident clear.
        if (bus.clr_status) begin
            overrun_d    = 1'b0;
            break_seen_d = 1'b0;
        end
        if (drop) overrun_d = 1'b1;
        if (brk_rise) break_seen_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overrun_q    <= 1'b0;
            break_seen_q <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overrun_q    <= overrun_d;
            break_seen_q <= break_seen_d;
            brk_q        <= bus.rx_break;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= bus.rx_data;
    end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (level_d >= LvlW'(THRESH));
        end
    end

    assign bus.irq_thresh = irq_q;
`else
    assign bus.irq_thresh = 1'b0;
`endif

    assign bus.rx_en      = 1'b1;
    assign bus.rd_data    = empty ? '0 : mem[rd_ptr_q];
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.level      = level_q;
    assign bus.overrun    = overrun_q;
    assign bus.break_seen = break_seen_q;
endmodule
